// File: rtl/channel_sched_if.sv
// Handshake bundle between the channel scheduler, the operand mux / shared FP unit and the result buffer.
interface channel_sched_if #(
  parameter int NCH = 32,
  parameter int DW  = 21
);
  logic             start_i;
  logic [NCH-1:0]   ch_rdy_i;
  logic [4:0]       ch_sel_o;
  logic             issue_o;
  logic             fp_vld_i;
  logic [DW-1:0]    fp_in_i;
  logic             srdyo_o;
  logic [DW-1:0]    res_out_o;
  logic             busy_o;
  logic             done_o;
  logic             err_o;

  modport slave (
    input  start_i, ch_rdy_i, fp_vld_i, fp_in_i,
    output ch_sel_o, issue_o, srdyo_o, res_out_o, busy_o, done_o, err_o
  );

  modport master (
    output start_i, ch_rdy_i, fp_vld_i, fp_in_i,
    input  ch_sel_o, issue_o, srdyo_o, res_out_o, busy_o, done_o, err_o
  );
endinterface

// File: rtl/channel_sched.sv
// Issues 32 channels in strict order to a shared FP unit and collects their results.
// Optional stall watchdog enabled by defining STALL_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for start; outputs quiet
// ISSUE | offering channel idx to the FP unit, in order, one per ready cycle
// DRAIN | all issued (or aborted); waiting for outstanding results
module channel_sched #(
  parameter int NCH = 32,
  parameter int DW  = 21,
  parameter int TMO = 255
) (
  input  logic            clk,
  input  logic            reset,
  channel_sched_if.slave  bus
);

  if (NCH != 32 || TMO < 1 || TMO > 255) begin : g_bad_cfg
    $error("channel_sched: NCH must be 32 and TMO must be 1..255");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [4:0]     idx_q, idx_d;
  logic [5:0]     out_q, out_d;
  logic [5:0]     ret_q, ret_d;
  logic           err_q, err_d;
  logic           srdyo_q;
  logic           cnt_vld_q;
  logic [DW-1:0]  res_q;

  logic           issue;
  logic           fp_ok;
  logic           fp_bad;
  logic           ret_hit;
  logic           done;

`ifdef STALL_TIMEOUT_EN
  logic [7:0]     stall_q, stall_d;
  logic           abort_q, abort_d;
`endif

  assign issue   = (state_q == S_ISSUE) && bus.ch_rdy_i[idx_q];
  assign fp_ok   = bus.fp_vld_i && (out_q != 6'd0);
  assign fp_bad  = bus.fp_vld_i && (out_q == 6'd0);
  assign ret_hit = srdyo_q && cnt_vld_q;

  // The 32nd counted result is the one being presented on srdyo this cycle.
`ifdef STALL_TIMEOUT_EN
  assign done = ((state_q != S_IDLE) && ret_hit && (ret_q == 6'(NCH - 1)))
             || ((state_q == S_DRAIN) && abort_q && (out_q == 6'd0));
`else
  assign done = (state_q != S_IDLE) && ret_hit && (ret_q == 6'(NCH - 1));
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    out_d   = out_q + {5'd0, issue} - {5'd0, fp_ok};
    ret_d   = ret_q + {5'd0, ret_hit};
    err_d   = err_q | fp_bad;
`ifdef STALL_TIMEOUT_EN
    stall_d = stall_q;
    abort_d = abort_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          state_d = S_ISSUE;
          idx_d   = 5'd0;
          out_d   = 6'd0;
          ret_d   = 6'd0;
`ifdef STALL_TIMEOUT_EN
          stall_d = 8'd0;
          abort_d = 1'b0;
`endif
        end
      end
      S_ISSUE: begin
        if (issue) begin
          idx_d = idx_q + 5'd1;
          if (idx_q == 5'(NCH - 1)) state_d = S_DRAIN;
        end
`ifdef STALL_TIMEOUT_EN
        if (issue) begin
          stall_d = 8'd0;
        end else begin
          stall_d = stall_q + 8'd1;
          if (stall_q == 8'(TMO - 1)) begin
            err_d   = 1'b1;
            abort_d = 1'b1;
            state_d = S_DRAIN;
          end
        end
`endif
      end
      S_DRAIN: begin
        if (done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      idx_q     <= 5'd0;
      out_q     <= 6'd0;
      ret_q     <= 6'd0;
      err_q     <= 1'b0;
      srdyo_q   <= 1'b0;
      cnt_vld_q <= 1'b0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      out_q     <= out_d;
      ret_q     <= ret_d;
      err_q     <= err_d;
      srdyo_q   <= bus.fp_vld_i;
      cnt_vld_q <= fp_ok;
      res_q     <= bus.fp_in_i;
    end
  end

`ifdef STALL_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= 8'd0;
      abort_q <= 1'b0;
    end else begin
      stall_q <= stall_d;
      abort_q <= abort_d;
    end
  end
`endif

  assign bus.ch_sel_o  = (state_q == S_IDLE) ? 5'd0 : idx_q;
  assign bus.issue_o   = issue;
  assign bus.srdyo_o   = srdyo_q;
  assign bus.res_out_o = res_q;
  assign bus.busy_o    = (state_q != S_IDLE);
  assign bus.done_o    = done;
  assign bus.err_o     = err_q;

endmodule

// File: tb/tb_channel_sched.sv
// Randomized bench for channel_sched against an event-level frame model (default build).
module tb_channel_sched;
  localparam int DW = 21;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  channel_sched_if #(.NCH(32), .DW(DW)) bus ();

  channel_sched #(.NCH(32), .DW(DW), .TMO(255)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // frame model: counts of issued / outstanding / returned results
  bit            m_in_frame;
  int            m_issued;
  int            m_out;
  int            m_ret;
  bit            m_err;
  bit            m_pfv;
  logic [DW-1:0] m_pfd;
  bit            m_pcnt;

  // FP unit model: due cycles of pending results, fixed latency per frame
  int fq[$];
  int lat = 4;
  int rdy_mode = 0;
  int hold_ch = -1;
  int hold_left = 0;

  bit obs_done, obs_srdyo, obs_hold;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h want %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_in_frame = 0; m_issued = 0; m_out = 0; m_ret = 0;
    m_err = 0; m_pfv = 0; m_pfd = '0; m_pcnt = 0;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    #1;
    chk("rst_ch_sel", bus.ch_sel_o, 0);
    chk("rst_issue",  bus.issue_o, 0);
    chk("rst_srdyo",  bus.srdyo_o, 0);
    chk("rst_res",    bus.res_out_o, 0);
    chk("rst_busy",   bus.busy_o, 0);
    chk("rst_done",   bus.done_o, 0);
    chk("rst_err",    bus.err_o, 0);
    model_clear();
    bus.start_i  = 1'b0;
    bus.fp_vld_i = 1'b0;
    repeat (2) begin @(posedge clk); #1; cyc++; end
    reset = 1'b1;
  endtask

  task automatic step(input bit st, input bit spur, input logic [DW-1:0] spur_d);
    logic [31:0]   rdy;
    logic          fv;
    logic [DW-1:0] fd;
    bit            e_iss, e_done, cnt;
    int            e_sel;
    rdy = '1;
    if (rdy_mode == 2) rdy = $urandom | $urandom;
    if (m_in_frame && m_issued == hold_ch && hold_left > 0) begin
      rdy[hold_ch] = 1'b0;
      hold_left--;
    end
    while (fq.size() > 0 && fq[0] < cyc) void'(fq.pop_front());
    fv = 1'b0;
    fd = DW'($urandom);
    if (fq.size() > 0 && fq[0] == cyc) begin
      fv = 1'b1;
      void'(fq.pop_front());
    end
    if (spur) begin
      fv = 1'b1;
      fd = spur_d;
    end
    bus.start_i  = st;
    bus.ch_rdy_i = rdy;
    bus.fp_vld_i = fv;
    bus.fp_in_i  = fd;
    #4;
    e_sel  = (m_in_frame && m_issued < 32) ? m_issued : 0;
    e_iss  = m_in_frame && (m_issued < 32) && rdy[e_sel[4:0]];
    e_done = m_in_frame && m_pcnt && (m_ret == 31);
    chk("busy",    bus.busy_o, m_in_frame);
    chk("ch_sel",  bus.ch_sel_o, e_sel);
    chk("issue",   bus.issue_o, e_iss);
    chk("srdyo",   bus.srdyo_o, m_pfv);
    chk("res_out", bus.res_out_o, m_pfd);
    chk("done",    bus.done_o, e_done);
    chk("err",     bus.err_o, m_err);
    obs_done  = bus.done_o;
    obs_srdyo = bus.srdyo_o;
    obs_hold  = bus.busy_o && (bus.ch_sel_o == 5'd5) && !bus.issue_o;
    cnt = fv && (m_out > 0);
    if (fv && m_out == 0) m_err = 1;
    m_out = m_out + int'(e_iss) - int'(cnt);
    if (m_in_frame && m_pcnt) m_ret++;
    if (e_iss) begin
      m_issued++;
      fq.push_back(cyc + lat);
    end
    if (e_done) m_in_frame = 0;
    else if (!m_in_frame && st) begin
      m_in_frame = 1; m_issued = 0; m_out = 0; m_ret = 0;
    end
    m_pfv = fv; m_pfd = fd; m_pcnt = cnt;
    @(posedge clk); #1; cyc++;
  endtask

  task automatic run_frame(input int extra_at, input int exp_hold);
    int n, dones, srd, hs;
    n = 0; dones = 0; srd = 0; hs = 0;
    step(1'b1, 1'b0, '0);
    dones += int'(obs_done); srd += int'(obs_srdyo);
    while (m_in_frame && n < 3000) begin
      step(n == extra_at, 1'b0, '0);
      dones += int'(obs_done); srd += int'(obs_srdyo); hs += int'(obs_hold);
      n++;
    end
    chk("done_cnt", dones, 1);
    chk("srdyo_cnt", srd, 32);
    if (exp_hold >= 0) chk("hold_cycles", hs, exp_hold);
    repeat (2) step(1'b0, 1'b0, '0);
  endtask

  initial begin
    bus.start_i  = 1'b0;
    bus.ch_rdy_i = '0;
    bus.fp_vld_i = 1'b0;
    bus.fp_in_i  = '0;
    model_clear();
    #1;
    apply_reset();

    // all channels ready, latency 4
    rdy_mode = 0; lat = 4;
    run_frame(-1, -1);

    // channel 5 not ready for 10 cycles
    hold_ch = 5; hold_left = 10; lat = 3;
    run_frame(-1, 10);
    hold_ch = -1; hold_left = 0;

    // repeated start at cycle 3 of the frame
    lat = 5;
    run_frame(2, -1);

    // random readiness, latencies and stray starts
    rdy_mode = 2;
    for (int f = 0; f < 6; f++) begin
      lat = $urandom_range(1, 6);
      run_frame($urandom_range(0, 40), -1);
    end

    // stray FP result while idle
    rdy_mode = 0;
    step(1'b0, 1'b1, 21'h1ABCD);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);

    // reset after 12 issues, stale results afterwards, then a full frame
    lat = 4;
    step(1'b1, 1'b0, '0);
    while (m_issued < 12) step(1'b0, 1'b0, '0);
    apply_reset();
    repeat (8) step(1'b0, 1'b0, '0);
    run_frame(-1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
